pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 145 ++++++++++++++
 tb/tb_pwm_capture.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of pwm_in in prescaled ticks, flags a stuck input.
// Build macro PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-sample majority filter after the synchronizer.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int DIV     = 10,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_lvl
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic sync1_q, sync2_q, lvl_dly_q, lvl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            lvl_dly_q <= 1'b0;
        end else begin
            sync1_q   <= pwm_in;
            sync2_q   <= sync1_q;
            lvl_dly_q <= lvl;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Majority of the current and two previous samples rejects 1-clk pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
            filt_q <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    logic          rise, fall;
    assign rise = lvl & ~lvl_dly_q;
    assign fall = ~lvl & lvl_dly_q;

    logic [PW-1:0] pre_q;
    logic          tick;
    assign tick = (pre_q == PRE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
        end
    end

    state_t           state_q;
    logic [CNT_W-1:0] hi_q, per_q;
    logic [CNT_W-1:0] first_val, hi_inc, per_inc;

    assign first_val = tick ? CNT_W'(1) : '0;
    assign hi_inc    = (tick && hi_q != CNT_MAX) ? hi_q + 1'b1 : hi_q;
    assign per_inc   = (tick && per_q != CNT_MAX) ? per_q + 1'b1 : per_q;

    // A rising edge always restarts both counters; it takes priority over a timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            per_q      <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
            stuck_lvl  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                hi_q    <= '0;
                per_q   <= '0;
            end else if (rise) begin
                state_q <= HIGH;
                hi_q    <= first_val;
                per_q   <= first_val;
                if (state_q == LOW) begin
                    high_cnt   <= hi_q;
                    period_cnt <= per_q;
                    valid      <= 1'b1;
                end
                if (state_q == IDLE) begin
                    stuck <= 1'b0;
                end
            end else begin
                case (state_q)
                    HIGH, LOW: begin
                        if (per_q >= TMO) begin
                            stuck     <= 1'b1;
                            stuck_lvl <= lvl;
                            state_q   <= IDLE;
                            hi_q      <= '0;
                            per_q     <= '0;
                        end else begin
                            per_q <= per_inc;
                            if (state_q == HIGH && !fall) begin
                                hi_q <= hi_inc;
                            end
                            if (fall) begin
                                state_q <= LOW;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        hi_q    <= '0;
                        per_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: one DIV=1/TIMEOUT=50 instance and one DIV=10 instance, checked against a duration-based model.
module tb_pwm_capture;
    localparam int W   = 16;
    localparam int TMO = 50;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int EDGE_LAT = 5;
`else
    localparam int EDGE_LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         pwm_in = 1'b0;
    logic         en10 = 1'b1;
    logic         pwm10 = 1'b0;
    logic [W-1:0] high_cnt, period_cnt, high_cnt10, period_cnt10;
    logic         valid, stuck, stuck_lvl, valid10, stuck10, stuck_lvl10;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] obs_q[$];
    logic [2*W-1:0] obs10_q[$];
    int   dbl_valid = 0;
    int   dbl_valid10 = 0;
    logic valid_prev = 1'b0;
    logic valid10_prev = 1'b0;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(W), .DIV(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .valid(valid),
        .stuck(stuck), .stuck_lvl(stuck_lvl)
    );

    pwm_capture #(.CNT_W(W), .DIV(10), .TIMEOUT(1000)) dut10 (
        .clk(clk), .rst(rst), .en(en10), .pwm_in(pwm10),
        .high_cnt(high_cnt10), .period_cnt(period_cnt10), .valid(valid10),
        .stuck(stuck10), .stuck_lvl(stuck_lvl10)
    );

    // Observed measurements, collected away from the active edge.
    always @(negedge clk) begin
        if (valid) obs_q.push_back({high_cnt, period_cnt});
        if (valid && valid_prev) dbl_valid++;
        valid_prev = valid;
        if (valid10) obs10_q.push_back({high_cnt10, period_cnt10});
        if (valid10 && valid10_prev) dbl_valid10++;
        valid10_prev = valid10;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        pwm_in = 1'b0;
        pwm10 = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        obs10_q.delete();
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Drives n periods then one closing rising edge; a period of high h and low l reads back as (h, h+l).
    task automatic run_periods(input int n, input bit rnd, input int fh, input int fl);
        int h, l;
        for (int i = 0; i < n; i++) begin
            h = rnd ? int'($urandom_range(3, 20)) : fh;
            l = rnd ? int'($urandom_range(3, 20)) : fl;
            drive(1'b1, h);
            drive(1'b0, l);
            exp_q.push_back({16'(h), 16'(h + l)});
        end
        drive(1'b1, 4);
        drive(1'b0, 4);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (high_cnt !== 16'd0) begin errors++; $display("FAIL reset_high_cnt: got %0d expected 0", high_cnt); end
        checks++; if (period_cnt !== 16'd0) begin errors++; $display("FAIL reset_period_cnt: got %0d expected 0", period_cnt); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
        checks++; if (stuck_lvl !== 1'b0) begin errors++; $display("FAIL reset_stuck_lvl: got %b expected 0", stuck_lvl); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (valid !== 1'b0 || stuck !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got valid=%b stuck=%b expected 0 0", valid, stuck); end
    endtask

    task automatic test_fixed_pattern();
        logic [2*W-1:0] e, o;
        do_reset();
        run_periods(7, 1'b0, 4, 6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fixed_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL fixed_meas: got high=%0d period=%0d expected high=%0d period=%0d", o[2*W-1:W], o[W-1:0], e[2*W-1:W], e[W-1:0]); end
        end
    endtask

    task automatic test_random_periods();
        logic [2*W-1:0] e, o;
        do_reset();
        run_periods(12, 1'b1, 0, 0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL random_meas: got high=%0d period=%0d expected high=%0d period=%0d", o[2*W-1:W], o[W-1:0], e[2*W-1:W], e[W-1:0]); end
        end
    endtask

    task automatic test_stuck();
        int cyc;
        // Held high: stuck appears EDGE_LAT + TIMEOUT clocks after the rising edge is driven.
        do_reset();
        pwm_in = 1'b1;
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (stuck) break;
        end
        checks++; if (cyc !== EDGE_LAT + TMO) begin errors++; $display("FAIL stuck_high_time: got %0d clk expected %0d", cyc, EDGE_LAT + TMO); end
        checks++; if (stuck_lvl !== 1'b1) begin errors++; $display("FAIL stuck_high_lvl: got %b expected 1", stuck_lvl); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL stuck_high_valid: got %0d pulses expected 0", obs_q.size()); end
        drive(1'b0, 6);
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL stuck_hold_on_fall: got %b expected 1", stuck); end
        drive(1'b1, EDGE_LAT + 2);
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL stuck_clear: got %b expected 0", stuck); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL stuck_clear_valid: got %0d pulses expected 0", obs_q.size()); end
        // Held low after a short high: same timing, captured level low.
        do_reset();
        drive(1'b1, 5);
        pwm_in = 1'b0;
        for (cyc = 6; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (stuck) break;
        end
        checks++; if (cyc !== EDGE_LAT + TMO) begin errors++; $display("FAIL stuck_low_time: got %0d clk expected %0d", cyc, EDGE_LAT + TMO); end
        checks++; if (stuck_lvl !== 1'b0) begin errors++; $display("FAIL stuck_low_lvl: got %b expected 0", stuck_lvl); end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] e, o;
        do_reset();
        run_periods(2, 1'b0, 5, 7);
        drive(1'b1, 8);
        rst = 1'b0;
        #1;
        checks++; if (high_cnt !== 16'd0 || period_cnt !== 16'd0) begin errors++; $display("FAIL midreset_counts: got high=%0d period=%0d expected 0 0", high_cnt, period_cnt); end
        checks++; if (valid !== 1'b0 || stuck !== 1'b0 || stuck_lvl !== 1'b0) begin errors++; $display("FAIL midreset_flags: got valid=%b stuck=%b lvl=%b expected 0 0 0", valid, stuck, stuck_lvl); end
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_periods(3, 1'b1, 0, 0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL midreset_meas: got high=%0d period=%0d expected high=%0d period=%0d", o[2*W-1:W], o[W-1:0], e[2*W-1:W], e[W-1:0]); end
        end
    endtask

    task automatic test_en_drop();
        logic [2*W-1:0] e, o;
        do_reset();
        run_periods(2, 1'b0, 6, 9);
        exp_q.delete();
        obs_q.delete();
        en = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (high_cnt !== 16'd6 || period_cnt !== 16'd15) begin errors++; $display("FAIL en_hold: got high=%0d period=%0d expected 6 15", high_cnt, period_cnt); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL en_valid: got %0d pulses expected 0", obs_q.size()); end
        en = 1'b1;
        drive(1'b0, 5);
        run_periods(3, 1'b1, 0, 0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL en_resume_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL en_resume_meas: got high=%0d period=%0d expected high=%0d period=%0d", o[2*W-1:W], o[W-1:0], e[2*W-1:W], e[W-1:0]); end
        end
    endtask

    task automatic test_glitch();
        logic [2*W-1:0] e, o;
        do_reset();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        exp_q.push_back({16'd5, 16'd25});
`else
        exp_q.push_back({16'd5, 16'd13});
        exp_q.push_back({16'd1, 16'd12});
`endif
        drive(1'b1, 5);
        drive(1'b0, 8);
        drive(1'b1, 1);
        drive(1'b0, 11);
        drive(1'b1, 4);
        drive(1'b0, 4);
        repeat (8) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL glitch_meas: got high=%0d period=%0d expected high=%0d period=%0d", o[2*W-1:W], o[W-1:0], e[2*W-1:W], e[W-1:0]); end
        end
    endtask

    task automatic test_prescaled();
        logic [2*W-1:0] o;
        do_reset();
        repeat ($urandom_range(0, 9)) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            pwm10 = 1'b1; repeat (40) @(negedge clk);
            pwm10 = 1'b0; repeat (60) @(negedge clk);
        end
        pwm10 = 1'b1; repeat (40) @(negedge clk);
        pwm10 = 1'b0; repeat (20) @(negedge clk);
        checks++;
        if (obs10_q.size() != 6) begin errors++; $display("FAIL div10_count: got %0d pulses expected 6", obs10_q.size()); end
        while (obs10_q.size() > 0) begin
            o = obs10_q.pop_front(); checks++;
            if (o[2*W-1:W] < 4 || o[2*W-1:W] > 5 || o[W-1:0] < 9 || o[W-1:0] > 11) begin
                errors++; $display("FAIL div10_meas: got high=%0d period=%0d expected high 4..5 period 9..11", o[2*W-1:W], o[W-1:0]);
            end
        end
    endtask

    task automatic test_valid_pulse();
        checks++; if (dbl_valid != 0) begin errors++; $display("FAIL valid_double: got %0d back-to-back pulses expected 0", dbl_valid); end
        checks++; if (dbl_valid10 != 0) begin errors++; $display("FAIL valid10_double: got %0d back-to-back pulses expected 0", dbl_valid10); end
    endtask

    initial begin
        test_reset();
        test_fixed_pattern();
        test_random_periods();
        test_stuck();
        test_reset_mid();
        test_en_drop();
        test_glitch();
        test_prescaled();
        test_valid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
